// File: rtl/mem_responder_if.sv
// ---------------------------------------------------------------------------
// mem_responder_if
//   Bus between the control unit (master) and the memory responder (slave).
//   Request side : w_read, w_write, i_addr, i_wdata
//   Preload side : e_load, i_load_addr, i_load_data
//   Response side: w_Mdatain, o_mem_ready, o_busy, o_err
// ---------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic                  w_read;
    logic                  w_write;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic [DATA_WIDTH-1:0] i_wdata;
    logic                  e_load;
    logic [ADDR_WIDTH-1:0] i_load_addr;
    logic [DATA_WIDTH-1:0] i_load_data;
    logic [DATA_WIDTH-1:0] w_Mdatain;
    logic                  o_mem_ready;
    logic                  o_busy;
    logic                  o_err;

    modport master (
        output w_read, w_write, i_addr, i_wdata,
        output e_load, i_load_addr, i_load_data,
        input  w_Mdatain, o_mem_ready, o_busy, o_err
    );

    modport slave (
        input  w_read, w_write, i_addr, i_wdata,
        input  e_load, i_load_addr, i_load_data,
        output w_Mdatain, o_mem_ready, o_busy, o_err
    );
endinterface

// File: rtl/mem_responder.sv
// ---------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the MDR/MAR interface. Accepts a read or write
//   strobe in IDLE, waits WAIT_STATES cycles, then spends one cycle in RESP
//   with o_mem_ready high. Owns a word-addressed RAM that can be preloaded
//   while idle.
// Ports
//   w_clock  : rising-edge clock
//   w_clear  : synchronous active-high reset (RAM contents are kept)
//   bus      : mem_responder_if.slave (request, preload and response signals)
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | accept one request, flag double strobe, or take a preload
// WAIT   | wait-state down-counter running, strobes ignored
// RESP   | one-cycle ready pulse; write commits on the edge leaving RESP
// ---------------------------------------------------------------------------
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic           w_clock,
    input  logic           w_clear,
    mem_responder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit       HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] CNT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t                state_q, state_nxt;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  op_write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mdatain_q;

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    logic                  req_one;
    logic                  req_both;
    logic                  accept;
    logic                  enter_resp;
    logic                  rd_op;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  load_ok;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    assign req_one  = bus.w_read ^ bus.w_write;
    assign req_both = bus.w_read & bus.w_write;
    assign accept   = (state_q == ST_IDLE) && req_one;

    // State register
    always_ff @(posedge w_clock) begin
        if (w_clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_one) begin
                    state_nxt = HAS_WAIT ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.o_busy      = 1'b0;
        bus.o_mem_ready = 1'b0;
        case (state_q)
            ST_WAIT: bus.o_busy = 1'b1;
            ST_RESP: begin
                bus.o_busy      = 1'b1;
                bus.o_mem_ready = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.o_err     = err_q;
    assign bus.w_Mdatain = mdatain_q;

    // With zero wait states RESP is entered straight from IDLE, so the read
    // must use the live request rather than the captured one.
    assign enter_resp = (state_nxt == ST_RESP) && (state_q != ST_RESP);
    assign rd_op      = (state_q == ST_IDLE) ? (bus.w_read & ~bus.w_write) : ~op_write_q;
    assign rd_addr    = (state_q == ST_IDLE) ? bus.i_addr : addr_q;

    always_ff @(posedge w_clock) begin
        if (w_clear) begin
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
            mdatain_q  <= '0;
        end else begin
            err_q <= (state_q == ST_IDLE) && req_both;
            if (accept) begin
                addr_q     <= bus.i_addr;
                wdata_q    <= bus.i_wdata;
                op_write_q <= bus.w_write;
                cnt_q      <= CNT_LOAD;
            end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_resp && rd_op) begin
                mdatain_q <= mem[rd_addr];
            end
        end
    end

    // Single RAM write port: preload in IDLE (only with no strobe present),
    // access write on the edge leaving RESP. Reset suppresses both.
    assign load_ok = (state_q == ST_IDLE) && bus.e_load && !bus.w_read && !bus.w_write;
    assign mem_we  = !w_clear && (load_ok || ((state_q == ST_RESP) && op_write_q));

    always_comb begin
        mem_waddr = bus.i_load_addr;
        mem_wdata = bus.i_load_data;
        if (state_q == ST_RESP) begin
            mem_waddr = addr_q;
            mem_wdata = wdata_q;
        end
    end

    always_ff @(posedge w_clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b1 ();
    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) b0 ();

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(1)) dut1 (
        .w_clock (clk),
        .w_clear (clr),
        .bus     (b1)
    );

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .w_clock (clk),
        .w_clear (clr),
        .bus     (b0)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [8:0] a, input logic [31:0] d);
        b1.e_load = 1'b1; b1.i_load_addr = a; b1.i_load_data = d;
        step();
        b1.e_load = 1'b0;
    endtask

    task automatic load0(input logic [8:0] a, input logic [31:0] d);
        b0.e_load = 1'b1; b0.i_load_addr = a; b0.i_load_data = d;
        step();
        b0.e_load = 1'b0;
    endtask

    // Raise strobes just after edge 0, drop them after edge 1, watch edges 1..5.
    task automatic run1(input logic rd, input logic wr, input logic [8:0] a, input logic [31:0] d,
                        output int rdy_edge, output int rdy_cnt, output int busy_cnt, output int err_cnt);
        b1.w_read = rd; b1.w_write = wr; b1.i_addr = a; b1.i_wdata = d;
        rdy_edge = -1; rdy_cnt = 0; busy_cnt = 0; err_cnt = 0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 1) begin b1.w_read = 1'b0; b1.w_write = 1'b0; end
            if (b1.o_mem_ready) begin rdy_cnt++; if (rdy_edge < 0) rdy_edge = e; end
            if (b1.o_busy) busy_cnt++;
            if (b1.o_err) err_cnt++;
        end
    endtask

    task automatic test_reset();
        int re, rc, bc, ec;
        clr = 1'b1;
        step(); step();
        total++; if (b1.o_mem_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", b1.o_mem_ready); end
        total++; if (b1.o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", b1.o_busy); end
        total++; if (b1.o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", b1.o_err); end
        total++; if (b1.w_Mdatain !== 32'h0) begin bad++; $display("FAIL rst_mdatain got=%h want=0", b1.w_Mdatain); end
        total++; if (b0.w_Mdatain !== 32'h0 || b0.o_busy !== 1'b0) begin bad++; $display("FAIL rst_dut0 got=%h/%b want=0/0", b0.w_Mdatain, b0.o_busy); end
        clr = 1'b0;
        load1(9'd5, 32'hA5A50005);
        run1(1'b1, 1'b0, 9'd5, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'hA5A50005) begin bad++; $display("FAIL rst_preread got=%h want=a5a50005", b1.w_Mdatain); end
        clr = 1'b1;
        step(); step();
        clr = 1'b0;
        total++; if (b1.w_Mdatain !== 32'h0) begin bad++; $display("FAIL rst_clears_mdatain got=%h want=0", b1.w_Mdatain); end
        run1(1'b1, 1'b0, 9'd5, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'hA5A50005) begin bad++; $display("FAIL rst_ram_kept got=%h want=a5a50005", b1.w_Mdatain); end
    endtask

    task automatic test_read_latency();
        int re, rc, bc, ec;
        load1(9'd0, 32'h28918000);
        run1(1'b1, 1'b0, 9'd0, 32'h0, re, rc, bc, ec);
        total++; if (re !== 2) begin bad++; $display("FAIL rd_ready_edge got=%0d want=2", re); end
        total++; if (rc !== 1) begin bad++; $display("FAIL rd_ready_count got=%0d want=1", rc); end
        total++; if (bc !== 2) begin bad++; $display("FAIL rd_busy_cycles got=%0d want=2", bc); end
        total++; if (b1.w_Mdatain !== 32'h28918000) begin bad++; $display("FAIL rd_data got=%h want=28918000", b1.w_Mdatain); end
        step(); step(); step();
        total++; if (b1.w_Mdatain !== 32'h28918000) begin bad++; $display("FAIL rd_data_held got=%h want=28918000", b1.w_Mdatain); end
    endtask

    task automatic test_write_readback();
        int re, rc, bc, ec;
        run1(1'b0, 1'b1, 9'h1FF, 32'hF0000012, re, rc, bc, ec);
        total++; if (re !== 2 || rc !== 1) begin bad++; $display("FAIL wr_ready got=%0d/%0d want=2/1", re, rc); end
        total++; if (bc !== 2 || ec !== 0) begin bad++; $display("FAIL wr_busy_err got=%0d/%0d want=2/0", bc, ec); end
        total++; if (b1.w_Mdatain !== 32'h28918000) begin bad++; $display("FAIL wr_keeps_mdatain got=%h want=28918000", b1.w_Mdatain); end
        run1(1'b1, 1'b0, 9'h1FF, 32'h0, re, rc, bc, ec);
        total++; if (bc !== 2 || ec !== 0) begin bad++; $display("FAIL rb_busy_err got=%0d/%0d want=2/0", bc, ec); end
        total++; if (b1.w_Mdatain !== 32'hF0000012) begin bad++; $display("FAIL rb_data got=%h want=f0000012", b1.w_Mdatain); end
    endtask

    task automatic test_both_strobes();
        int re, rc, bc, ec;
        load1(9'd3, 32'h11112222);
        run1(1'b1, 1'b1, 9'd3, 32'hDEADBEEF, re, rc, bc, ec);
        total++; if (ec !== 1) begin bad++; $display("FAIL both_err_cycles got=%0d want=1", ec); end
        total++; if (rc !== 0 || bc !== 0) begin bad++; $display("FAIL both_no_access got=%0d/%0d want=0/0", rc, bc); end
        run1(1'b1, 1'b0, 9'd3, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'h11112222) begin bad++; $display("FAIL both_ram_same got=%h want=11112222", b1.w_Mdatain); end
    endtask

    task automatic test_load_conflict();
        int re, rc, bc, ec;
        load1(9'd4, 32'h44444444);
        load1(9'd6, 32'h60606060);
        b1.e_load = 1'b1; b1.i_load_addr = 9'd4; b1.i_load_data = 32'h99999999;
        b1.w_read = 1'b1; b1.i_addr = 9'd4;
        step();
        b1.w_read = 1'b0;
        b1.i_load_addr = 9'd6; b1.i_load_data = 32'h66666666;
        step();
        b1.e_load = 1'b0;
        step(); step();
        total++; if (b1.w_Mdatain !== 32'h44444444) begin bad++; $display("FAIL load_drop_read got=%h want=44444444", b1.w_Mdatain); end
        run1(1'b1, 1'b0, 9'd4, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'h44444444) begin bad++; $display("FAIL load_dropped got=%h want=44444444", b1.w_Mdatain); end
        run1(1'b1, 1'b0, 9'd6, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'h60606060) begin bad++; $display("FAIL load_in_wait got=%h want=60606060", b1.w_Mdatain); end
    endtask

    task automatic test_reset_abort();
        int re, rc, bc, ec;
        int rdy = 0;
        load1(9'd7, 32'h77770000);
        b1.w_write = 1'b1; b1.i_addr = 9'd7; b1.i_wdata = 32'h00000018;
        step();
        b1.w_write = 1'b0;
        total++; if (b1.o_busy !== 1'b1) begin bad++; $display("FAIL abort_in_wait got=%b want=1", b1.o_busy); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++; if (b1.o_busy !== 1'b0 || b1.o_mem_ready !== 1'b0) begin bad++; $display("FAIL abort_idle got=%b/%b want=0/0", b1.o_busy, b1.o_mem_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            if (b1.o_mem_ready) rdy++;
        end
        total++; if (rdy !== 0) begin bad++; $display("FAIL abort_no_ready got=%0d want=0", rdy); end
        run1(1'b1, 1'b0, 9'd7, 32'h0, re, rc, bc, ec);
        total++; if (b1.w_Mdatain !== 32'h77770000) begin bad++; $display("FAIL abort_no_write got=%h want=77770000", b1.w_Mdatain); end
    endtask

    task automatic test_zero_wait();
        logic [5:0] rdy_mask = '0;
        logic [5:0] busy_mask = '0;
        load0(9'd2, 32'hCAFE0002);
        b0.w_read = 1'b1; b0.i_addr = 9'd2;
        for (int e = 1; e <= 6; e++) begin
            step();
            rdy_mask[e-1]  = b0.o_mem_ready;
            busy_mask[e-1] = b0.o_busy;
            if (e == 4) b0.w_read = 1'b0;
        end
        total++; if (rdy_mask !== 6'b000101) begin bad++; $display("FAIL zw_ready_mask got=%b want=000101", rdy_mask); end
        total++; if (busy_mask !== 6'b000101) begin bad++; $display("FAIL zw_busy_mask got=%b want=000101", busy_mask); end
        total++; if (b0.w_Mdatain !== 32'hCAFE0002) begin bad++; $display("FAIL zw_data got=%h want=cafe0002", b0.w_Mdatain); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] rdy_mask = '0;
        b0.w_write = 1'b1; b0.i_addr = 9'd10; b0.i_wdata = 32'h0000BEEF;
        for (int e = 1; e <= 6; e++) begin
            step();
            rdy_mask[e-1] = b0.o_mem_ready;
            if (e == 1) begin b0.w_write = 1'b0; b0.w_read = 1'b1; end
            if (e == 3) b0.w_read = 1'b0;
        end
        total++; if (rdy_mask !== 6'b000101) begin bad++; $display("FAIL b2b_ready_mask got=%b want=000101", rdy_mask); end
        total++; if (b0.w_Mdatain !== 32'h0000BEEF) begin bad++; $display("FAIL b2b_raw_data got=%h want=0000beef", b0.w_Mdatain); end
    endtask

    initial begin
        clr = 1'b1;
        b1.w_read = 1'b0; b1.w_write = 1'b0; b1.i_addr = '0; b1.i_wdata = '0;
        b1.e_load = 1'b0; b1.i_load_addr = '0; b1.i_load_data = '0;
        b0.w_read = 1'b0; b0.w_write = 1'b0; b0.i_addr = '0; b0.i_wdata = '0;
        b0.e_load = 1'b0; b0.i_load_addr = '0; b0.i_load_data = '0;
        test_reset();
        test_read_latency();
        test_write_readback();
        test_both_strobes();
        test_load_conflict();
        test_reset_abort();
        test_zero_wait();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
